ysyx_22041211_lsu: RTL and testbench

Load/store unit stage, directly upstream of the writeback stage. Accepts one instruction at a time from the execute stage over a valid/ready handshake. Performs at most one data-memory transaction on a req/gnt/rvalid bus, with byte-lane alignment and load sign/zero extension. Presents wd/wreg/wdata to writeback over a second valid/ready handshake. Replaces combinational DPI memory access with a multi-cycle, stallable bus.

---
 rtl/ysyx_22041211_lsu.sv | 144 ++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: one instruction at a time, a single req/gnt/rvalid bus transaction,
// byte-lane alignment and load extension, with a registered result toward writeback.
module ysyx_22041211_lsu #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] alu_result_i,
    input  logic [2:0]          load_type_i,
    input  logic [1:0]          store_type_i,
    input  logic [DATA_LEN-1:0] mem_wdata_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [3:0]          mem_wstrb_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ld_type_q;
    logic [1:0]          off_q;

    logic                ld_ok, st_ok, is_half, is_word, misal, accept, capture;
    logic [1:0]          off;
    logic [3:0]          wstrb;
    logic [DATA_LEN-1:0] st_data, lane, ld_ext;

    // Decode of the instruction offered by EXU; a valid load wins over a store.
    always_comb begin
        off     = alu_result_i[1:0];
        ld_ok   = (load_type_i != 3'd0) && (load_type_i <= 3'd5);
        st_ok   = !ld_ok && (store_type_i != 2'd0);
        is_half = ld_ok ? (load_type_i == 3'd2 || load_type_i == 3'd5) : (st_ok && store_type_i == 2'd2);
        is_word = ld_ok ? (load_type_i == 3'd3) : (st_ok && store_type_i == 2'd3);
        misal   = (is_half && off[0]) || (is_word && off != 2'd0);
        wstrb   = 4'd0;
        st_data = mem_wdata_i;
        if (st_ok) begin
            case (store_type_i)
                2'd1: begin
                    wstrb   = 4'(4'b0001 << off);
                    st_data = {4{mem_wdata_i[7:0]}};
                end
                2'd2: begin
                    wstrb   = 4'(4'b0011 << off);
                    st_data = {2{mem_wdata_i[15:0]}};
                end
                default: wstrb = 4'b1111;
            endcase
        end
    end

    // Lane extraction of the returned word for the latched load type.
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        case (ld_type_q)
            3'd1:    ld_ext = {{(DATA_LEN-8){lane[7]}}, lane[7:0]};
            3'd2:    ld_ext = {{(DATA_LEN-16){lane[15]}}, lane[15:0]};
            3'd4:    ld_ext = {{(DATA_LEN-8){1'b0}}, lane[7:0]};
            3'd5:    ld_ext = {{(DATA_LEN-16){1'b0}}, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid_i) begin
                accept  = 1'b1;
                state_d = ((ld_ok || st_ok) && !misal) ? S_REQ : S_DONE;
            end
            S_REQ: if (mem_gnt_i) begin
                capture = mem_rvalid_i;
                state_d = mem_rvalid_i ? S_DONE : S_WAIT;
            end
            S_WAIT: if (mem_rvalid_i) begin
                capture = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, bus request and writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_o  <= 1'b1;
            mem_req_o   <= 1'b0;
            out_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= 4'd0;
            wd_o        <= 1'b0;
            wreg_o      <= 5'd0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
            ld_type_q   <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_o  <= (state_d == S_IDLE);
            mem_req_o   <= (state_d == S_REQ);
            out_valid_o <= (state_d == S_DONE);
            if (accept) begin
                wd_o       <= wd_i && !misal;
                wreg_o     <= wreg_i;
                wdata_o    <= alu_result_i;
                misalign_o <= misal;
                ld_type_q  <= ld_ok ? load_type_i : 3'd0;
                off_q      <= off;
                if (state_d == S_REQ) begin
                    mem_we_o    <= st_ok;
                    mem_addr_o  <= {alu_result_i[ADDR_LEN-1:2], 2'b00};
                    mem_wdata_o <= st_data;
                    mem_wstrb_o <= wstrb;
                end
            end
            if (capture && ld_type_q != 3'd0) wdata_o <= ld_ext;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for ysyx_22041211_lsu with a scoreboard of expected writeback results.
module tb_ysyx_22041211_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_ready_o, wd_i;
    logic [4:0]  wreg_i;
    logic [31:0] alu_result_i, mem_wdata_i;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic        out_valid_o, out_ready_i, wd_o, misalign_o;
    logic [4:0]  wreg_o;
    logic [31:0] wdata_o;

    typedef struct packed {
        logic        wd;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ysyx_22041211_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i), .mem_wdata_i(mem_wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata, input logic mis);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.mis = mis;
        sb.push_back(e);
    endtask

    // Offer an instruction; returns at the negedge right after it was accepted.
    task automatic send(input logic wd, input logic [4:0] wreg, input logic [31:0] alu,
                        input logic [2:0] ld, input logic [1:0] st, input logic [31:0] sdata);
        int n = 0;
        in_valid_i = 1'b1; wd_i = wd; wreg_i = wreg; alu_result_i = alu;
        load_type_i = ld; store_type_i = st; mem_wdata_i = sdata;
        while (!in_ready_o && n < 20) begin @(negedge clk); n++; end
        chk("accept_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    // Bus responder: gnt after gnt_lat stall cycles, rvalid rv_lat cycles after gnt.
    task automatic mem_txn(input int gnt_lat, input int rv_lat, input logic [31:0] rdata,
                           input logic [31:0] addr, input logic we, input logic [3:0] strb,
                           input logic [31:0] wdata);
        for (int i = 0; i <= gnt_lat; i++) begin
            chk("req_held", 32'(mem_req_o), 32'd1);
            chk("req_addr", mem_addr_o, addr);
            chk("req_we", 32'(mem_we_o), 32'(we));
            chk("req_wstrb", 32'(mem_wstrb_o), 32'(strb));
            if (we) chk("req_wdata", mem_wdata_o, wdata);
            if (i == gnt_lat) begin
                mem_gnt_i = 1'b1;
                if (rv_lat == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdata; end
            end
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        end
        for (int j = 1; j <= rv_lat; j++) begin
            chk("wait_no_req", 32'(mem_req_o), 32'd0);
            if (j == rv_lat) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdata; end
            @(negedge clk);
            mem_rvalid_i = 1'b0;
        end
    endtask

    // Wait (bounded) for out_valid and compare against the scoreboard head.
    task automatic collect(input string tag);
        int   n = 0;
        exp_t e;
        while (!out_valid_o && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (out_valid_o && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_wd"}, 32'(wd_o), 32'(e.wd));
            chk({tag, "_wreg"}, 32'(wreg_o), 32'(e.wreg));
            chk({tag, "_wdata"}, wdata_o, e.wdata);
            chk({tag, "_mis"}, 32'(misalign_o), 32'(e.mis));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; wd_i = 1'b0; wreg_i = 5'd0; alu_result_i = 32'd0;
        load_type_i = 3'd0; store_type_i = 2'd0; mem_wdata_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ALU op: result one cycle after accept, no bus traffic
        push(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        send(1'b1, 5'd5, 32'h1234, 3'd0, 2'd0, 32'd0);
        chk("alu_valid_1cyc", 32'(out_valid_o), 32'd1);
        chk("alu_no_req", 32'(mem_req_o), 32'd0);
        collect("alu");
        @(negedge clk);
        chk("alu_drop", 32'(out_valid_o), 32'd0);
        chk("alu_ready", 32'(in_ready_o), 32'd1);

        // LB / LBU at byte 3, gnt 2 cycles late
        push(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0);
        send(1'b1, 5'd6, 32'h8000_0003, 3'd1, 2'd0, 32'd0);
        mem_txn(2, 1, 32'h80FF_0000, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        collect("lb");
        @(negedge clk);
        push(1'b1, 5'd7, 32'h0000_0080, 1'b0);
        send(1'b1, 5'd7, 32'h8000_0003, 3'd4, 2'd0, 32'd0);
        mem_txn(2, 1, 32'h80FF_0000, 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
        collect("lbu");
        @(negedge clk);

        // LH / LHU upper half; then misaligned LH
        push(1'b1, 5'd8, 32'hFFFF_8001, 1'b0);
        send(1'b1, 5'd8, 32'h1000_0002, 3'd2, 2'd0, 32'd0);
        mem_txn(0, 1, 32'h8001_7FFF, 32'h1000_0000, 1'b0, 4'b0000, 32'd0);
        collect("lh");
        @(negedge clk);
        push(1'b1, 5'd9, 32'h0000_8001, 1'b0);
        send(1'b1, 5'd9, 32'h1000_0002, 3'd5, 2'd0, 32'd0);
        mem_txn(1, 2, 32'h8001_7FFF, 32'h1000_0000, 1'b0, 4'b0000, 32'd0);
        collect("lhu");
        @(negedge clk);
        push(1'b0, 5'd10, 32'h1000_0001, 1'b1);
        send(1'b1, 5'd10, 32'h1000_0001, 3'd2, 2'd0, 32'd0);
        chk("mis_no_req", 32'(mem_req_o), 32'd0);
        collect("lh_mis");
        @(negedge clk);

        // SB with gnt and rvalid together; SH at upper half
        push(1'b0, 5'd0, 32'h2000_0002, 1'b0);
        send(1'b0, 5'd0, 32'h2000_0002, 3'd0, 2'd1, 32'h0000_00AB);
        mem_txn(0, 0, 32'd0, 32'h2000_0000, 1'b1, 4'b0100, 32'hABAB_ABAB);
        chk("sb_done_next", 32'(out_valid_o), 32'd1);
        collect("sb");
        @(negedge clk);
        push(1'b0, 5'd0, 32'h2000_0006, 1'b0);
        send(1'b0, 5'd0, 32'h2000_0006, 3'd0, 2'd2, 32'h1234_CDEF);
        mem_txn(0, 1, 32'd0, 32'h2000_0004, 1'b1, 4'b1100, 32'hCDEF_CDEF);
        collect("sh");
        @(negedge clk);

        // WB backpressure on an LW, with the next instruction already offered
        out_ready_i = 1'b0;
        push(1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0);
        send(1'b1, 5'd11, 32'h3000_0000, 3'd3, 2'd0, 32'd0);
        mem_txn(0, 1, 32'hDEAD_BEEF, 32'h3000_0000, 1'b0, 4'b0000, 32'd0);
        push(1'b1, 5'd12, 32'h0000_0042, 1'b0);
        in_valid_i = 1'b1; wd_i = 1'b1; wreg_i = 5'd12; alu_result_i = 32'h42;
        load_type_i = 3'd0; store_type_i = 2'd0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 32'(out_valid_o), 32'd1);
            chk("bp_wdata", wdata_o, 32'hDEAD_BEEF);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        collect("bp_lw");
        @(negedge clk);
        chk("bp_idle_ready", 32'(in_ready_o), 32'd1);
        chk("bp_drop", 32'(out_valid_o), 32'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        collect("bp_next");
        @(negedge clk);

        // Reset while waiting for rvalid; the late response must be ignored
        send(1'b1, 5'd13, 32'h4000_0000, 3'd3, 2'd0, 32'd0);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("pre_rst_wait", 32'(mem_req_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
        chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        rst = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("late_rv_valid", 32'(out_valid_o), 32'd0);
        chk("late_rv_ready", 32'(in_ready_o), 32'd1);
        push(1'b1, 5'd14, 32'h0000_0055, 1'b0);
        send(1'b1, 5'd14, 32'h55, 3'd0, 2'd0, 32'd0);
        collect("post_rst");
        @(negedge clk);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
